seq_detect_param: RTL and testbench

Parametrised serial pattern detector, the successor to the fixed 4-bit "0110" Moore detector. It accepts one bit per qualified clock and matches against a compile-time pattern of width PAT_W. It supports run-time overlapping and non-overlapping match modes, and counts matches in a saturating counter. It sits directly on a serial bit stream (UART/LFSR/bench stimulus) and drives a one-cycle match pulse to downstream logic.

---
 rtl/seq_detect_param.sv | 67 ++++++
 tb/tb_seq_detect_param.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/seq_detect_param.sv
// seq_detect_param: parametrised serial pattern detector with overlap control and saturating match counter
// Optional feature: define SEQDET_COUNT_EN to build the match counter; otherwise match_cnt is tied to 0.
module seq_detect_param #(
    parameter int             PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b0110,
    parameter int             CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    input  logic             in,
    input  logic             overlap,
    input  logic             clr,
    output logic             out,
    output logic [CNT_W-1:0] match_cnt
);
    localparam int FW = $clog2(PAT_W + 1);

    logic [PAT_W-1:0] hist_q, hist_d, hist_n;
    logic [FW-1:0]    fill_q, fill_d, fill_n;
    logic             out_q, out_d, hit;

    // Candidate history/fill for an accepted bit; fill gating keeps reset-zero history from matching.
    always_comb begin
        hist_n = {hist_q[PAT_W-2:0], in};
        fill_n = (fill_q == FW'(PAT_W)) ? fill_q : fill_q + FW'(1);
        hit    = in_valid && !clr && (fill_n == FW'(PAT_W)) && (hist_n == PATTERN);
        hist_d = clr ? '0 : in_valid ? hist_n : hist_q;
        fill_d = clr ? '0 : !in_valid ? fill_q : (hit && !overlap) ? '0 : fill_n;
        out_d  = hit;
    end

    // History, fill and match pulse registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hist_q <= '0;
            fill_q <= '0;
            out_q  <= 1'b0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            out_q  <= out_d;
        end
    end

    assign out = out_q;

`ifdef SEQDET_COUNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Saturating match count, cleared by clr, held at all-ones.
    always_comb begin
        cnt_d = clr ? '0 : (hit && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
    end

    // Match counter register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign match_cnt = cnt_q;
`else
    assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// tb_seq_detect_param: scoreboard bench driving two detector instances (PATTERN 0110/CNT_W 8 and PATTERN 0000/CNT_W 2)
module tb_seq_detect_param;
    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       vld = 1'b0;
    logic       din = 1'b0;
    logic       ovl = 1'b1;
    logic       clr = 1'b0;
    logic       out_a, out_b;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;

    seq_detect_param dut_a (
        .clk(clk), .rstn(rstn), .in_valid(vld), .in(din), .overlap(ovl), .clr(clr),
        .out(out_a), .match_cnt(cnt_a)
    );

    seq_detect_param #(.PAT_W(4), .PATTERN(4'b0000), .CNT_W(2)) dut_b (
        .clk(clk), .rstn(rstn), .in_valid(vld), .in(din), .overlap(ovl), .clr(clr),
        .out(out_b), .match_cnt(cnt_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       oa;
        logic [7:0] ca;
        logic       ob;
        logic [1:0] cb;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference: each instance keeps the bits accepted since the last restart point
    // (reset, clr, or a non-overlapping match); a match is the last four such bits equalling the pattern.
    bit         hq[2][$];
    int         mcnt[2];
    logic [3:0] pat[2];
    int         cmax[2];

    initial begin
        pat[0] = 4'b0110; cmax[0] = 255;
        pat[1] = 4'b0000; cmax[1] = 3;
        mcnt[0] = 0; mcnt[1] = 0;
    end

    function automatic bit accept(int k, bit b, bit ov);
        logic [3:0] v;
        bit         h;
        int         n;
        hq[k].push_back(b);
        n = hq[k].size();
        v = '0;
        if (n >= 4)
            for (int i = n - 4; i < n; i++) v = {v[2:0], hq[k][i]};
        h = (n >= 4) && (v == pat[k]);
        if (h) begin
            if (mcnt[k] < cmax[k]) mcnt[k]++;
            if (!ov) hq[k].delete();
        end
        return h;
    endfunction

    function automatic int cnt_exp(int k);
`ifdef SEQDET_COUNT_EN
        return mcnt[k];
`else
        return 0;
`endif
    endfunction

    task automatic cyc(bit r, bit v, bit b, bit ov, bit c);
        exp_t e;
        bit   h[2];
        @(negedge clk);
        rstn = !r; vld = v; din = b; ovl = ov; clr = c;
        for (int k = 0; k < 2; k++) begin
            h[k] = 1'b0;
            if (r || c) begin
                hq[k].delete();
                mcnt[k] = 0;
            end else if (v) begin
                h[k] = accept(k, b, ov);
            end
        end
        e.oa = h[0]; e.ca = 8'(cnt_exp(0));
        e.ob = h[1]; e.cb = 2'(cnt_exp(1));
        sb.push_back(e);
    endtask

    task automatic stream(input bit bits[], bit ov);
        foreach (bits[i]) cyc(0, 1, bits[i], ov, 0);
    endtask

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%0d expected=%0d", name, $time, act, exp);
        end
    endfunction

    // Monitor: one expectation is retired per clock edge once stimulus has issued it.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("out_a", int'(out_a), int'(e.oa));
                chk("cnt_a", int'(cnt_a), int'(e.ca));
                chk("out_b", int'(out_b), int'(e.ob));
                chk("cnt_b", int'(cnt_b), int'(e.cb));
            end
        end
    end

    initial begin
        bit s1[] = '{0, 1, 1, 0, 1, 1, 0};
        bit s4[] = '{0, 1, 1, 0};
        bit s3[] = '{0, 1, 1};
        bit z8[] = '{0, 0, 0, 0, 0, 0, 0, 0};
        int guard;
        repeat (2) cyc(1, 0, 0, 1, 0);
        stream(s1, 1);
        cyc(0, 0, 0, 1, 1);
        stream(s1, 0);
        cyc(0, 0, 0, 1, 1);
        foreach (s4[i]) begin
            cyc(0, 1, s4[i], 1, 0);
            repeat (2) cyc(0, 0, 1'($urandom_range(0, 1)), 1, 0);
        end
        cyc(0, 0, 0, 1, 1);
        stream(s3, 1);
        cyc(1, 0, 0, 1, 0);
        cyc(0, 1, 0, 1, 0);
        stream(s4, 1);
        stream(s3, 1);
        cyc(0, 1, 0, 1, 1);
        cyc(0, 0, 0, 1, 0);
        cyc(1, 0, 0, 1, 0);
        stream(z8, 1);
        cyc(1, 0, 0, 1, 0);
        stream(z8, 0);
        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0,
                1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0,
                $urandom_range(0, 39) == 0);
        cyc(0, 0, 0, 1, 0);
        guard = 0;
        while (sb.size() > 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        #2;
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain pending=%0d expected=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
